// File: rtl/sched_pkg.sv
// Shared types and constants for the TDMA burst scheduler.
// Holds the FSM state encoding, the GSM timing defaults and a counter-width helper.
package sched_pkg;

  localparam int SYMS_PER_SLOT   = 156;
  localparam int SLOTS_PER_FRAME = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    WAIT_IQ,
    ACTIVE,
    COOLDOWN
  } sched_state_e;

  // Width of one counter able to hold the largest of the three strobe counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_idx [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_idx
    assign w_idx[g] = PTR_W'((int'(i_ptr) + g) % N_REQ);
  end

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_valid && i_req[w_idx[i]]) begin
        o_grant[w_idx[i]] = 1'b1;
        o_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdma_burst_scheduler.sv
// TDMA slot/frame timing plus round-robin burst sequencing for the shared tx_burst chain.
// Optional per-slot requester mask enabled by defining SCHED_SLOT_MASK_EN.
module tdma_burst_scheduler
  import sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SLOT_LEN    = SYMS_PER_SLOT,
  parameter int FRAME_SLOTS = SLOTS_PER_FRAME,
  parameter int FRAME_BITS  = 11,
  parameter int PA_LEAD     = 3,
  parameter int PA_TAIL     = 2,
  parameter int ARM_TIMEOUT = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           symbol_strobe_i,
  input  logic                           armed_i,
  input  logic                           iq_valid_i,
  input  logic [N_REQ-1:0]               req_i,
`ifdef SCHED_SLOT_MASK_EN
  input  logic [N_REQ*FRAME_SLOTS-1:0]   slot_mask_i,
`endif
  output logic                           fire_burst_o,
  output logic                           pa_en_o,
  output logic [N_REQ-1:0]               grant_o,
  output logic [N_REQ-1:0]               done_o,
  output logic                           timeout_o,
  output logic                           busy_o,
  output logic [$clog2(FRAME_SLOTS)-1:0] slot_o,
  output logic [FRAME_BITS-1:0]          frame_o
);

  localparam int SYM_W  = $clog2(SLOT_LEN);
  localparam int SLOT_W = $clog2(FRAME_SLOTS);
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CNT_W  = cnt_width(PA_LEAD, PA_TAIL, ARM_TIMEOUT);

  logic [SYM_W-1:0]      r_sym_cnt;
  logic [SLOT_W-1:0]     r_slot;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  w_slot_start;
  logic                  w_last_slot;
  logic [SLOT_W-1:0]     w_next_slot;

  assign w_slot_start = symbol_strobe_i && (r_sym_cnt == SYM_W'(SLOT_LEN - 1));
  assign w_last_slot  = (r_slot == SLOT_W'(FRAME_SLOTS - 1));
  assign w_next_slot  = w_last_slot ? '0 : r_slot + 1'b1;

  // NOTE: asynchronous reset sits in the sensitivity list; every register here takes <= only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sym_cnt <= '0;
      r_slot    <= '0;
      r_frame   <= '0;
    end else if (symbol_strobe_i) begin
      r_sym_cnt <= w_slot_start ? '0 : r_sym_cnt + 1'b1;
      if (w_slot_start) begin
        r_slot <= w_next_slot;
        if (w_last_slot) r_frame <= r_frame + 1'b1;
      end
    end
  end

  logic [N_REQ-1:0] w_elig;
`ifdef SCHED_SLOT_MASK_EN
  // Eligibility is judged against the slot that this strobe opens, not the one closing.
  for (genvar k = 0; k < N_REQ; k++) begin : g_mask
    assign w_elig[k] = req_i[k] & slot_mask_i[k*FRAME_SLOTS + int'(w_next_slot)];
  end
`else
  assign w_elig = req_i;
`endif

  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] w_arb_grant;
  logic             w_arb_valid;
  logic [PTR_W-1:0] w_win_idx;
  logic [PTR_W-1:0] w_ptr_nxt;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_grant[i]) w_win_idx = PTR_W'(i);
    end
  end

  assign w_ptr_nxt = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  sched_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic             r_pa_en, w_pa_nxt;
  logic             r_fire, w_fire_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic             r_timed_out, w_timed_out_nxt;
  logic             w_ptr_upd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_pa_en     <= 1'b0;
      r_fire      <= 1'b0;
      r_tmo       <= 1'b0;
      r_timed_out <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_pa_en     <= w_pa_nxt;
      r_fire      <= w_fire_nxt;
      r_tmo       <= w_tmo_nxt;
      r_timed_out <= w_timed_out_nxt;
      if (w_ptr_upd) r_ptr <= w_ptr_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_grant_nxt     = r_grant;
    w_pa_nxt        = r_pa_en;
    w_timed_out_nxt = r_timed_out;
    w_done_nxt      = '0;
    w_fire_nxt      = 1'b0;
    w_tmo_nxt       = 1'b0;
    w_ptr_upd       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_slot_start && armed_i && w_arb_valid) begin
          w_grant_nxt     = w_arb_grant;
          w_pa_nxt        = 1'b1;
          w_cnt_nxt       = '0;
          w_timed_out_nxt = 1'b0;
          w_ptr_upd       = 1'b1;
          w_state_nxt     = LEAD;
        end
      end
      LEAD: begin
        if (PA_LEAD == 0 || (symbol_strobe_i && r_cnt == CNT_W'(PA_LEAD - 1))) begin
          w_fire_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_IQ;
        end else if (symbol_strobe_i) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_IQ: begin
        if (iq_valid_i) begin
          w_state_nxt = ACTIVE;
        end else if (symbol_strobe_i) begin
          if (r_cnt == CNT_W'(ARM_TIMEOUT - 1)) begin
            w_tmo_nxt       = 1'b1;
            w_timed_out_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = COOLDOWN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!iq_valid_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (PA_TAIL == 0 || (symbol_strobe_i && r_cnt == CNT_W'(PA_TAIL - 1))) begin
          w_pa_nxt    = 1'b0;
          w_grant_nxt = '0;
          w_done_nxt  = r_timed_out ? '0 : r_grant;
          w_state_nxt = IDLE;
        end else if (symbol_strobe_i) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign fire_burst_o = r_fire;
  assign pa_en_o      = r_pa_en;
  assign grant_o      = r_grant;
  assign done_o       = r_done;
  assign timeout_o    = r_tmo;
  assign busy_o       = (r_state != IDLE);
  assign slot_o       = r_slot;
  assign frame_o      = r_frame;

endmodule

// File: tb/tb_tdma_burst_scheduler.sv
// Scoreboard bench for tdma_burst_scheduler: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_tdma_burst_scheduler;

  localparam int N_REQ = 4;

  logic             clock;
  logic             reset;
  logic             symbol_strobe_i;
  logic             armed_i;
  logic             iq_valid_i;
  logic [N_REQ-1:0] req_i;
  logic             fire_burst_o;
  logic             pa_en_o;
  logic [N_REQ-1:0] grant_o;
  logic [N_REQ-1:0] done_o;
  logic             timeout_o;
  logic             busy_o;
  logic [2:0]       slot_o;
  logic [10:0]      frame_o;

  tdma_burst_scheduler #(
    .N_REQ       (N_REQ),
    .SLOT_LEN    (4),
    .FRAME_SLOTS (8),
    .FRAME_BITS  (11),
    .PA_LEAD     (2),
    .PA_TAIL     (1),
    .ARM_TIMEOUT (5)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .symbol_strobe_i (symbol_strobe_i),
    .armed_i         (armed_i),
    .iq_valid_i      (iq_valid_i),
    .req_i           (req_i),
    .fire_burst_o    (fire_burst_o),
    .pa_en_o         (pa_en_o),
    .grant_o         (grant_o),
    .done_o          (done_o),
    .timeout_o       (timeout_o),
    .busy_o          (busy_o),
    .slot_o          (slot_o),
    .frame_o         (frame_o)
  );

  typedef enum logic [3:0] {EV_SLOT, EV_GRANT, EV_FIRE, EV_TMO, EV_END} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [3:0]  phase;
    logic [15:0] val;
    logic [15:0] strobe;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  strobe_no = 0;
  int  phase_cnt = 0;
  int  busy_hits = 0;
  int  gcyc = 0;
  bit  mon_slot_en = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Strobe every 4 clocks, free-running through reset.
  initial begin
    symbol_strobe_i = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      gcyc++;
      symbol_strobe_i = (gcyc % 4 == 0);
    end
  end

  // Count strobes the DUT sees since reset release and clocks since the last one.
  always @(posedge clock) begin
    if (reset) begin
      strobe_no <= 0;
      phase_cnt <= 0;
    end else if (symbol_strobe_i) begin
      strobe_no <= strobe_no + 1;
      phase_cnt <= 0;
    end else begin
      phase_cnt <= phase_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [15:0] v, input int s);
    ev_t e;
    e.kind   = k;
    e.phase  = 4'd0;
    e.val    = v;
    e.strobe = 16'(s);
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [15:0] v);
    ev_t o;
    ev_t e;
    o.kind   = k;
    o.phase  = (phase_cnt > 15) ? 4'hf : 4'(phase_cnt);
    o.val    = v;
    o.strobe = 16'(strobe_no);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_%s: got %h expected none", k.name(), o);
    end else begin
      e = exp_q.pop_front();
      check({"event_", k.name()}, 64'(o), 64'(e));
    end
  endtask

  // Monitor: event order within one sample is SLOT, GRANT, FIRE, TMO, END.
  initial begin
    logic [N_REQ-1:0] prev_grant;
    logic [2:0]       prev_slot;
    prev_grant = '0;
    prev_slot  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mon_slot_en && slot_o != prev_slot) observe(EV_SLOT, 16'({frame_o, slot_o}));
        if (mon_slot_en && busy_o) busy_hits++;
        if (grant_o != '0 && grant_o != prev_grant) observe(EV_GRANT, 16'({pa_en_o, grant_o}));
        if (fire_burst_o) observe(EV_FIRE, 16'(grant_o));
        if (timeout_o) observe(EV_TMO, 16'({pa_en_o, grant_o, done_o}));
        if ((prev_grant != '0 && grant_o == '0) || done_o != '0)
          observe(EV_END, 16'({busy_o, pa_en_o, done_o}));
        prev_grant = grant_o;
      end else begin
        prev_grant = '0;
      end
      prev_slot = slot_o;
    end
  end

  task automatic wait_strobe(input int n);
    int guard;
    guard = 0;
    while (strobe_no < n) begin
      @(posedge clock);
      #1;
      guard++;
      if (guard > 500) begin
        n_checks++;
        n_errors++;
        $display("FAIL wait_strobe: got %0d expected %0d", strobe_no, n);
        return;
      end
    end
  endtask

  task automatic iq_pulse(input int cycles);
    iq_valid_i = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    iq_valid_i = 1'b0;
  endtask

  // Expected event bundle for a normal burst granted at slot-start strobe s.
  task automatic expect_burst(input int s, input logic [3:0] g, input int end_s);
    expect_ev(EV_GRANT, 16'({1'b1, g}), s);
    expect_ev(EV_FIRE, 16'(g), s + 2);
    expect_ev(EV_END, 16'({1'b0, 1'b0, g}), end_s);
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq[0] = 4'b0010;
    rr_seq[1] = 4'b0100;
    rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001;
    rr_seq[4] = 4'b0010;

    reset      = 1'b0;
    armed_i    = 1'b0;
    iq_valid_i = 1'b0;
    req_i      = '0;
    #1 reset = 1'b1;
    #1;
    check("reset_outputs",
          64'({fire_burst_o, pa_en_o, grant_o, done_o, timeout_o, busy_o, slot_o, frame_o}), 64'd0);

    // Free run: slot steps every 4 strobes, wraps to 0 with frame 1 at strobe 32.
    for (int k = 1; k <= 10; k++) expect_ev(EV_SLOT, 16'({11'(k / 8), 3'(k % 8)}), 4 * k);
    mon_slot_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    wait_strobe(40);
    @(negedge clock);
    #1;
    mon_slot_en = 1'b0;
    check("idle_busy_cycles", 64'(busy_hits), 64'd0);

    // Single burst for requester 0, iq_valid high 10 cycles; tail strobe 49.
    req_i   = 4'b0001;
    armed_i = 1'b1;
    expect_burst(44, 4'b0001, 49);
    wait_strobe(46);
    req_i = '0;
    iq_pulse(10);
    wait_strobe(49);

    // All four requesting: pointer sits at 1 after the previous winner 0.
    req_i = 4'b1111;
    for (int b = 0; b < 5; b++) expect_burst(52 + 4 * b, rr_seq[b], 55 + 4 * b);
    for (int b = 0; b < 5; b++) begin
      wait_strobe(54 + 4 * b);
      if (b == 4) req_i = '0;
      iq_pulse(2);
    end
    wait_strobe(71);

    // No iq_valid after fire: timeout 5 strobes later, release 1 strobe after that.
    req_i = 4'b0100;
    expect_ev(EV_GRANT, 16'({1'b1, 4'b0100}), 72);
    expect_ev(EV_FIRE, 16'(4'b0100), 74);
    expect_ev(EV_TMO, 16'({1'b1, 4'b0100, 4'b0000}), 79);
    expect_ev(EV_END, 16'({1'b0, 1'b0, 4'b0000}), 80);
    wait_strobe(74);
    req_i = '0;
    wait_strobe(80);

    // Not armed at slot start 84, armed by 88.
    req_i   = 4'b0010;
    armed_i = 1'b0;
    wait_strobe(84);
    armed_i = 1'b1;
    expect_ev(EV_GRANT, 16'({1'b1, 4'b0010}), 88);
    expect_ev(EV_FIRE, 16'(4'b0010), 90);
    wait_strobe(90);
    iq_valid_i = 1'b1;
    wait_strobe(91);
    check("pre_reset_active", 64'({busy_o, pa_en_o, grant_o}), 64'({1'b1, 1'b1, 4'b0010}));

    // Asynchronous reset mid-burst clears everything before the next clock edge.
    reset      = 1'b1;
    iq_valid_i = 1'b0;
    #1;
    check("midburst_reset_outputs",
          64'({fire_burst_o, pa_en_o, grant_o, done_o, timeout_o, busy_o, slot_o, frame_o}), 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Request still pending is re-served from pointer 0 after release.
    expect_burst(4, 4'b0010, 7);
    wait_strobe(6);
    req_i = '0;
    iq_pulse(2);
    wait_strobe(9);
    @(negedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
